// File: rtl/rv32i_single_cycle.sv
// Single-cycle RV32I core with word-indexed instruction and data memory ports.
// Define RV32_EBREAK_HALT_EN to make EBREAK halt the core until reset.
module rv32i_single_cycle #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic        write,
  input  logic [31:0] data_in,
  output logic [31:0] data_addr,
  output logic [31:0] data_out,
  output logic [31:0] pc
);

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcReg    = 7'b0110011;

  typedef enum logic [3:0] {
    OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad, OpStore, OpImm, OpReg, OpOther
  } op_e;

  op_e         op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] pc_q, pc_d, pc_inc, link;
  logic [31:0] rf_q [32];
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_u, br_off, jal_off;
  logic [31:0] alu_b, alu_res, ea;
  logic        alu_alt, br_taken;
  logic        rd_we;
  logic [31:0] rd_wdata;
  logic        stall;

  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u = {instr[31:12], 12'd0};
  // Branch/JAL byte offsets already arithmetically shifted right by two (word offsets).
  assign br_off  = {{22{instr[31]}}, instr[7], instr[30:25], instr[11:9]};
  assign jal_off = {{14{instr[31]}}, instr[19:12], instr[20], instr[30:22]};

  always_comb begin
    op = OpOther;
    unique case (instr[6:0])
      OpcLui:    op = OpLui;
      OpcAuipc:  op = OpAuipc;
      OpcJal:    op = OpJal;
      OpcJalr:   op = OpJalr;
      OpcBranch: op = OpBranch;
      OpcLoad:   op = OpLoad;
      OpcStore:  op = OpStore;
      OpcImm:    op = OpImm;
      OpcReg:    op = OpReg;
      default:   op = OpOther;
    endcase
  end

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  // instr[30] selects SUB only for register ops; for shifts it selects arithmetic.
  assign alu_b   = (op == OpReg) ? rs2_val : imm_i;
  assign alu_alt = instr[30] & ((funct3 == 3'b101) | ((op == OpReg) & (funct3 == 3'b000)));

  always_comb begin
    alu_res = 32'd0;
    unique case (funct3)
      3'b000: alu_res = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'b001: alu_res = rs1_val << alu_b[4:0];
      3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_res = {31'd0, rs1_val < alu_b};
      3'b100: alu_res = rs1_val ^ alu_b;
      3'b101: alu_res = alu_alt ? 32'($signed(rs1_val) >>> alu_b[4:0]) : (rs1_val >> alu_b[4:0]);
      3'b110: alu_res = rs1_val | alu_b;
      3'b111: alu_res = rs1_val & alu_b;
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    unique case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  assign ea        = rs1_val + ((op == OpStore) ? imm_s : imm_i);
  assign data_addr = ea >> 2;
  assign data_out  = rs2_val;
  assign pc_inc    = pc_q + 32'd1;
  assign link      = {pc_inc[29:0], 2'b00};
  assign pc        = pc_q;

`ifdef RV32_EBREAK_HALT_EN
  logic halted_q;
  logic is_ebreak;

  assign is_ebreak = (instr == 32'h0010_0073);
  assign stall     = halted_q | is_ebreak;

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (is_ebreak) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    pc_d     = pc_inc;
    rd_we    = 1'b0;
    rd_wdata = alu_res;
    write    = 1'b0;
    unique case (op)
      OpLui:    begin rd_we = 1'b1; rd_wdata = imm_u; end
      OpAuipc:  begin rd_we = 1'b1; rd_wdata = {pc_q[29:0], 2'b00} + imm_u; end
      OpJal:    begin rd_we = 1'b1; rd_wdata = link; pc_d = pc_q + jal_off; end
      // The &~1 of the JALR target is subsumed by dropping the two low bits.
      OpJalr:   begin rd_we = 1'b1; rd_wdata = link; pc_d = ea >> 2; end
      OpBranch: if (br_taken) pc_d = pc_q + br_off;
      OpLoad:   begin rd_we = 1'b1; rd_wdata = data_in; end
      OpStore:  write = 1'b1;
      OpImm, OpReg: rd_we = 1'b1;
      default: ;
    endcase
    if (stall) pc_d = pc_q;
    if (rst || stall) begin
      write = 1'b0;
      rd_we = 1'b0;
    end
    if (rd == 5'd0) rd_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      if (rd_we) rf_q[rd] <= rd_wdata;
    end
  end

endmodule

// File: tb/tb_rv32i_single_cycle.sv
// Self-checking bench for rv32i_single_cycle: directed vector table plus random
// instruction stream compared against an instruction-level reference model.
module tb_rv32i_single_cycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0000_0013;
  logic        write;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_addr, data_out, pc;

  always #5 clk = ~clk;

  rv32i_single_cycle #(.RESET_PC(32'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .write     (write),
    .data_in   (data_in),
    .data_addr (data_addr),
    .data_out  (data_out),
    .pc        (pc)
  );

  localparam logic [31:0] OP_LUI   = 32'h37;
  localparam logic [31:0] OP_AUIPC = 32'h17;
  localparam logic [31:0] OP_JALR  = 32'h67;
  localparam logic [31:0] OP_LD    = 32'h03;
  localparam logic [31:0] OP_ST    = 32'h23;
  localparam logic [31:0] OP_IMM   = 32'h13;
  localparam logic [31:0] OP_R     = 32'h33;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic [31:0] din;
    logic [31:0] pc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc_r(logic [31:0] f7, logic [31:0] r2, logic [31:0] r1,
                                        logic [31:0] f3, logic [31:0] rd, logic [31:0] op);
    return {f7[6:0], r2[4:0], r1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] enc_i(logic [31:0] imm, logic [31:0] r1, logic [31:0] f3,
                                        logic [31:0] rd, logic [31:0] op);
    return {imm[11:0], r1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] enc_s(logic [31:0] imm, logic [31:0] r2, logic [31:0] r1,
                                        logic [31:0] f3, logic [31:0] op);
    return {imm[11:5], r2[4:0], r1[4:0], f3[2:0], imm[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] enc_b(logic [31:0] imm, logic [31:0] r2, logic [31:0] r1,
                                        logic [31:0] f3);
    return {imm[12], imm[10:5], r2[4:0], r1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(logic [31:0] imm20, logic [31:0] rd, logic [31:0] op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] enc_j(logic [31:0] imm, logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Apply one instruction cycle; outputs are settled 1 time unit after the falling edge.
  task automatic drive(input logic r, input logic [31:0] ins, input logic [31:0] din);
    @(negedge clk);
    rst     = r;
    instr   = ins;
    data_in = din;
    #1;
  endtask

  task automatic add(input logic r, input logic [31:0] ins, input logic [31:0] din,
                     input logic [31:0] p, input logic we, input logic [31:0] addr,
                     input logic [31:0] dout);
    vecs.push_back('{r, ins, din, p, we, addr, dout});
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] p);
    add(1'b0, ins, 32'd0, p, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic st(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] addr,
                    input logic [31:0] dout);
    add(1'b0, ins, 32'd0, p, 1'b1, addr, dout);
  endtask

  task automatic rs(input logic [31:0] ins, input logic [31:0] p);
    add(1'b1, ins, 32'd0, p, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] regs [16];
  logic [31:0] mpc;

  initial begin
    // Reset vector table, ALU, memory, branches, jumps, x0, unknown opcode, pc wrap.
    step(enc_r(0, 0, 5, 0, 6, OP_R), 0);
    st(enc_s(0, 6, 0, 2, OP_ST), 1, 0, 0);
    step(enc_i(5, 0, 0, 1, OP_IMM), 2);
    step(enc_i(-3, 0, 0, 2, OP_IMM), 3);
    step(enc_r(0, 2, 1, 0, 3, OP_R), 4);
    step(enc_r(32'h20, 1, 2, 0, 4, OP_R), 5);
    step(enc_r(0, 2, 1, 3, 5, OP_R), 6);
    step(enc_i(32'h401, 2, 5, 6, OP_IMM), 7);
    st(enc_s(0, 3, 0, 2, OP_ST), 8, 0, 2);
    st(enc_s(4, 4, 0, 2, OP_ST), 9, 1, 32'hFFFF_FFF8);
    st(enc_s(8, 5, 0, 2, OP_ST), 10, 2, 1);
    st(enc_s(12, 6, 0, 2, OP_ST), 11, 3, 32'hFFFF_FFFE);
    step(enc_i(8, 0, 0, 1, OP_IMM), 12);
    st(enc_s(4, 1, 1, 2, OP_ST), 13, 3, 8);
    add(1'b0, enc_i(4, 1, 2, 2, OP_LD), 32'hDEAD_BEEF, 14, 1'b0, 32'd0, 32'd0);
    st(enc_s(0, 2, 0, 2, OP_ST), 15, 0, 32'hDEAD_BEEF);
    rs(enc_s(0, 1, 0, 2, OP_ST), 16);
    step(enc_i(-1, 0, 0, 8, OP_IMM), 0);
    step(enc_i(1, 0, 0, 9, OP_IMM), 1);
    step(NOP, 2);
    step(NOP, 3);
    step(enc_b(8, 0, 0, 0), 4);
    step(enc_b(8, 0, 0, 1), 6);
    step(enc_b(12, 9, 8, 4), 7);
    step(enc_b(12, 9, 8, 6), 10);
    step(enc_b(8, 9, 8, 5), 11);
    step(enc_b(-8, 9, 8, 7), 12);
    st(enc_s(0, 8, 0, 2, OP_ST), 10, 0, 32'hFFFF_FFFF);
    rs(enc_s(0, 9, 0, 2, OP_ST), 11);
    step(NOP, 0);
    step(NOP, 1);
    step(enc_j(16, 1), 2);
    st(enc_s(0, 1, 0, 2, OP_ST), 6, 0, 12);
    step(enc_i(0, 1, 0, 0, OP_JALR), 7);
    step(enc_u(0, 10, OP_AUIPC), 3);
    step(enc_u(32'h12345, 7, OP_LUI), 4);
    step(enc_i(77, 0, 0, 0, OP_IMM), 5);
    st(enc_s(0, 10, 0, 2, OP_ST), 6, 0, 12);
    st(enc_s(4, 7, 0, 2, OP_ST), 7, 1, 32'h1234_5000);
    st(enc_s(8, 0, 0, 2, OP_ST), 8, 2, 0);
    step(enc_i(5, 1, 0, 12, OP_JALR), 9);
    st(enc_s(-4, 12, 1, 2, OP_ST), 4, 2, 40);
    step(enc_r(0, 0, 0, 0, 12, 32'h0B), 5);
    st(enc_s(0, 12, 0, 2, OP_ST), 6, 0, 40);
    rs(enc_s(0, 7, 0, 2, OP_ST), 7);
    step(enc_j(-4, 0), 0);
    step(NOP, 32'hFFFF_FFFF);
    step(NOP, 0);

    // Two reset edges with a store presented: write must stay low.
    drive(1'b1, enc_s(0, 0, 0, 2, OP_ST), 0);
    drive(1'b1, enc_s(0, 0, 0, 2, OP_ST), 0);
    check("reset pc", pc, 32'd0);
    check("reset write", {31'd0, write}, 32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ins, vecs[i].din);
      check($sformatf("vec%0d pc", i), pc, vecs[i].pc);
      check($sformatf("vec%0d write", i), {31'd0, write}, {31'd0, vecs[i].we});
      if (vecs[i].we) begin
        check($sformatf("vec%0d addr", i), data_addr, vecs[i].addr);
        check($sformatf("vec%0d dout", i), data_out, vecs[i].dout);
      end
    end

    // EBREAK at pc=5.
    drive(1'b1, NOP, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, NOP, 0);
      check("halt lead pc", pc, i);
    end
`ifdef RV32_EBREAK_HALT_EN
    drive(1'b0, EBREAK, 0);
    check("ebreak pc", pc, 5);
    check("ebreak write", {31'd0, write}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, enc_s(0, 0, 0, 2, OP_ST), 0);
      check("halted pc", pc, 5);
      check("halted write", {31'd0, write}, 32'd0);
    end
    drive(1'b1, EBREAK, 0);
    drive(1'b0, NOP, 0);
    check("unhalt pc0", pc, 0);
    drive(1'b0, NOP, 0);
    check("unhalt pc1", pc, 1);
`else
    drive(1'b0, EBREAK, 0);
    check("ebreak nop pc", pc, 5);
    check("ebreak nop write", {31'd0, write}, 32'd0);
    drive(1'b0, NOP, 0);
    check("ebreak nop next pc", pc, 6);
`endif

    // Random instruction stream against the reference model.
    drive(1'b1, NOP, 0);
    mpc = 32'd0;
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    for (int n = 0; n < 400; n++) begin
      int          k, rd, r1, r2, off, sh;
      logic [31:0] a, b, si, t, ins, din, res, nxt, ea;
      logic        wr, we, tk;
      k   = $urandom_range(0, 33);
      rd  = $urandom_range(0, 15);
      r1  = $urandom_range(0, 15);
      r2  = $urandom_range(0, 15);
      sh  = $urandom_range(0, 31);
      a   = regs[r1];
      b   = regs[r2];
      t   = $urandom;
      si  = {{20{t[11]}}, t[11:0]};
      t   = $urandom & 32'h000F_FFFF;
      din = $urandom;
      wr  = 1'b1;
      we  = 1'b0;
      tk  = 1'b0;
      res = 32'd0;
      ins = NOP;
      nxt = mpc + 1;
      ea  = a + si;
      off = 0;
      case (k)
        0: begin ins = enc_u(t, rd, OP_LUI); res = t << 12; end
        1: begin ins = enc_u(t, rd, OP_AUIPC); res = mpc * 4 + (t << 12); end
        2: begin
          off = ($urandom_range(0, 511) - 256) * 2;
          ins = enc_j(off, rd);
          res = (mpc + 1) * 4;
          nxt = mpc + 32'(off >>> 2);
        end
        3: begin
          ins = enc_i(si, r1, 0, rd, OP_JALR);
          res = (mpc + 1) * 4;
          nxt = ((a + si) & ~32'd1) >> 2;
        end
        4, 5, 6, 7, 8, 9: begin
          wr  = 1'b0;
          off = ($urandom_range(0, 127) - 64) * 2;
          case (k)
            4: begin ins = enc_b(off, r2, r1, 0); tk = (a == b); end
            5: begin ins = enc_b(off, r2, r1, 1); tk = (a != b); end
            6: begin ins = enc_b(off, r2, r1, 4); tk = ($signed(a) < $signed(b)); end
            7: begin ins = enc_b(off, r2, r1, 5); tk = ($signed(a) >= $signed(b)); end
            8: begin ins = enc_b(off, r2, r1, 6); tk = (a < b); end
            default: begin ins = enc_b(off, r2, r1, 7); tk = (a >= b); end
          endcase
          if (tk) nxt = mpc + 32'(off >>> 2);
        end
        10: begin ins = enc_i(si, r1, 2, rd, OP_LD); res = din; end
        11: begin ins = enc_s(si, r2, r1, 2, OP_ST); wr = 1'b0; we = 1'b1; end
        12: begin ins = enc_i(si, r1, 0, rd, OP_IMM); res = a + si; end
        13: begin ins = enc_i(si, r1, 2, rd, OP_IMM); res = ($signed(a) < $signed(si)) ? 1 : 0; end
        14: begin ins = enc_i(si, r1, 3, rd, OP_IMM); res = (a < si) ? 1 : 0; end
        15: begin ins = enc_i(si, r1, 4, rd, OP_IMM); res = a ^ si; end
        16: begin ins = enc_i(si, r1, 6, rd, OP_IMM); res = a | si; end
        17: begin ins = enc_i(si, r1, 7, rd, OP_IMM); res = a & si; end
        18: begin ins = enc_i(sh, r1, 1, rd, OP_IMM); res = a << sh; end
        19: begin ins = enc_i(sh, r1, 5, rd, OP_IMM); res = a >> sh; end
        20: begin ins = enc_i(32'h400 | sh, r1, 5, rd, OP_IMM); res = $signed(a) >>> sh; end
        21: begin ins = enc_r(0, r2, r1, 0, rd, OP_R); res = a + b; end
        22: begin ins = enc_r(32'h20, r2, r1, 0, rd, OP_R); res = a - b; end
        23: begin ins = enc_r(0, r2, r1, 1, rd, OP_R); res = a << b[4:0]; end
        24: begin ins = enc_r(0, r2, r1, 2, rd, OP_R); res = ($signed(a) < $signed(b)) ? 1 : 0; end
        25: begin ins = enc_r(0, r2, r1, 3, rd, OP_R); res = (a < b) ? 1 : 0; end
        26: begin ins = enc_r(0, r2, r1, 4, rd, OP_R); res = a ^ b; end
        27: begin ins = enc_r(0, r2, r1, 6, rd, OP_R); res = a | b; end
        28: begin ins = enc_r(0, r2, r1, 7, rd, OP_R); res = a & b; end
        29: begin ins = enc_r(0, r2, r1, 5, rd, OP_R); res = a >> b[4:0]; end
        30: begin ins = enc_r(32'h20, r2, r1, 5, rd, OP_R); res = $signed(a) >>> b[4:0]; end
        31: begin ins = ($urandom & ~32'h7F) | 32'h0B; wr = 1'b0; end
        32: begin ins = enc_i(si, r1, 4, rd, OP_LD); res = din; end
        default: begin ins = enc_s(si, r2, r1, 0, OP_ST); wr = 1'b0; we = 1'b1; end
      endcase
      drive(1'b0, ins, din);
      check($sformatf("rnd%0d k%0d pc", n, k), pc, mpc);
      check($sformatf("rnd%0d k%0d write", n, k), {31'd0, write}, {31'd0, we});
      if (we) begin
        check($sformatf("rnd%0d addr", n), data_addr, ea >> 2);
        check($sformatf("rnd%0d dout", n), data_out, b);
      end
      if (wr && rd != 0) regs[rd] = res;
      mpc = nxt;
    end

    // Expose the final register file through stores.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, enc_s(4 * i, i, 0, 2, OP_ST), 0);
      check($sformatf("dump x%0d pc", i), pc, mpc);
      check($sformatf("dump x%0d write", i), {31'd0, write}, 32'd1);
      check($sformatf("dump x%0d addr", i), data_addr, i);
      check($sformatf("dump x%0d val", i), data_out, regs[i]);
      mpc = mpc + 1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
